rect_drawer: RTL
================

RECT_DRAWER -- requirements
Module: rect_drawer

Interface
REQ-001 SHALL have parameter COORD_W, default 11, width of every coordinate and dimension port.
REQ-002 SHALL have parameter COLOR_W, default 1, width of color and pix_color.
REQ-003 SHALL have parameter SCREEN_W, default 640, exclusive screen x limit.
REQ-004 SHALL have parameter SCREEN_H, default 480, exclusive screen y limit.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- x0, y0  in  COORD_W  top-left corner.
- w, h  in  COORD_W  width and height in pixels.
- outline  in  1  0 = filled, 1 = one-pixel border only.
- color  in  COLOR_W  pixel value.
- pix_ready  in  1  sink accepts the pixel this cycle.
- pix_valid  out  1  x, y and pix_color are a valid pixel.
- x, y  out  COORD_W  pixel coordinate.
- pix_color  out  COLOR_W  pixel value.
- busy  out  1  high in DRAW.
- done  out  1  one-cycle completion pulse.
- pix_count  out  2*COORD_W  pixels accepted in the current or most recent operation.

Function
REQ-006 SHALL implement states IDLE, DRAW and DONE.
REQ-007 In IDLE with start=1, SHALL latch x0, y0, w, h, outline and color, clear pix_count, and move to DRAW; inputs SHALL be ignored at all other times.
REQ-008 SHALL compute edges as xe = x0+w-1 and ye = y0+h-1 at COORD_W+1 bits, so there is no wrap-around.
REQ-009 SHALL clip at latch time: xl = min(xe, SCREEN_W-1), yl = min(ye, SCREEN_H-1).
REQ-010 A rectangle is empty if w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H; an empty rectangle SHALL go IDLE->DRAW->DONE with pix_valid never asserted and pix_count=0.
REQ-011 SHALL emit pixels in raster order: x from x0 to xl within a row, then y+1, ending at y0..yl.
REQ-012 In fill mode, SHALL emit every pixel in [x0..xl] x [y0..yl].
REQ-013 In outline mode:
- rows y0 and ye (if ye<=yl) SHALL emit x0..xl;
- every other row SHALL emit x0, then xe only if xe<=xl and xe!=x0;
- interior columns SHALL be skipped with no idle cycles.
REQ-014 In DRAW, pix_valid SHALL be 1 and x, y, pix_color SHALL hold stable until pix_valid && pix_ready.
REQ-015 Each accepted pixel SHALL advance to the next coordinate in the following cycle and increment pix_count, giving 1 pixel per cycle when pix_ready is held high.
REQ-016 Acceptance of the last pixel SHALL move the block to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a new start SHALL be accepted on the first IDLE cycle.
REQ-018 pix_valid SHALL be 0 in IDLE and DONE.
REQ-019 busy SHALL be 1 exactly in DRAW.
REQ-020 x and y SHALL hold their last driven values outside DRAW.
REQ-021 pix_count SHALL hold its value from DONE until the next accepted start.

Reset
REQ-022 reset=1 at any clock edge, including mid-DRAW, SHALL force IDLE and set pix_valid=0, busy=0, done=0, x=0, y=0, pix_color=0, pix_count=0.
REQ-023 An operation interrupted by reset SHALL be abandoned; no further pixels SHALL be emitted.
REQ-024 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-025 Fill: x0=20, y0=20, w=3, h=2, pix_ready=1 -> 6 pixels (20,20),(21,20),(22,20),(20,21),(21,21),(22,21) on consecutive cycles; done pulses the next cycle; pix_count=6.
REQ-026 Outline: x0=0, y0=0, w=4, h=4 -> 12 pixels, interior (1..2,1..2) absent, row 1 emits (0,1) then (3,1) back-to-back.
REQ-027 Backpressure: 2x2 fill with pix_ready toggling 1,0,0,1,... -> x, y and pix_color stable while stalled; exactly 4 acceptances; no duplicates.
REQ-028 Clip/empty:
- x0=638, y0=478, w=5, h=5 -> 4 pixels (638..639, 478..479);
- w=0 -> no pix_valid, done after 2 cycles, pix_count=0.
REQ-029 Reset mid-draw: 10x10 fill, reset asserted after 15 acceptances -> next cycle IDLE with all outputs 0; a new start then draws correctly from its own x0, y0.

Source files
------------

// File: rtl/rect_drawer.sv
`default_nettype none
// ============================================================================
// rect_drawer : streams filled or outlined rectangle pixels in raster order.
// Rev 1.0 - initial release
// ============================================================================
module rect_drawer #(
  parameter int COORD_W  = 11,
  parameter int COLOR_W  = 1,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COORD_W-1:0]     x0,
  input  logic [COORD_W-1:0]     y0,
  input  logic [COORD_W-1:0]     w,
  input  logic [COORD_W-1:0]     h,
  input  logic                   outline,
  input  logic [COLOR_W-1:0]     color,
  input  logic                   pix_ready,
  output logic                   pix_valid,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic [COLOR_W-1:0]     pix_color,
  output logic                   busy,
  output logic                   done,
  output logic [2*COORD_W-1:0]   pix_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COORD_W:0]     c_x_max   = (COORD_W+1)'(SCREEN_W - 1);
  localparam logic [COORD_W:0]     c_y_max   = (COORD_W+1)'(SCREEN_H - 1);
  localparam logic [COORD_W:0]     c_one_ext = (COORD_W+1)'(1);
  localparam logic [COORD_W-1:0]   c_step    = COORD_W'(1);
  localparam logic [2*COORD_W-1:0] c_cnt_one = (2*COORD_W)'(1);

  state_t             r_state;
  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_y0;
  logic [COORD_W:0]   r_xe;
  logic [COORD_W:0]   r_ye;
  logic [COORD_W:0]   r_xl;
  logic [COORD_W:0]   r_yl;
  logic               r_outline;

  // Edges carry one extra bit so x0+w-1 can exceed the coordinate range.
  logic [COORD_W:0] w_xe, w_ye, w_xl, w_yl;
  logic             w_empty;

  assign w_xe    = {1'b0, x0} + {1'b0, w} - c_one_ext;
  assign w_ye    = {1'b0, y0} + {1'b0, h} - c_one_ext;
  assign w_xl    = (w_xe > c_x_max) ? c_x_max : w_xe;
  assign w_yl    = (w_ye > c_y_max) ? c_y_max : w_ye;
  assign w_empty = (w == '0) || (h == '0) ||
                   ({1'b0, x0} > c_x_max) || ({1'b0, y0} > c_y_max);

  logic [COORD_W:0] w_x, w_y;
  logic             w_full_row, w_jump, w_row_more, w_last;

  assign w_x        = {1'b0, x};
  assign w_y        = {1'b0, y};
  assign w_full_row = !r_outline || (y == r_y0) || (w_y == r_ye);
  // Outline side rows: the left pixel hops straight to the right edge.
  assign w_jump     = !w_full_row && (x == r_x0) && (r_xe <= r_xl) &&
                      (r_xe != {1'b0, r_x0});
  assign w_row_more = w_full_row ? (w_x < r_xl) : w_jump;
  assign w_last     = !w_row_more && (w_y >= r_yl);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_xl      <= '0;
      r_yl      <= '0;
      r_outline <= 1'b0;
      pix_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      pix_color <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_count <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x0      <= x0;
            r_y0      <= y0;
            r_xe      <= w_xe;
            r_ye      <= w_ye;
            r_xl      <= w_xl;
            r_yl      <= w_yl;
            r_outline <= outline;
            pix_count <= '0;
            busy      <= 1'b1;
            r_state   <= DRAW;
            if (!w_empty) begin
              x         <= x0;
              y         <= y0;
              pix_color <= color;
              pix_valid <= 1'b1;
            end
          end
        end
        DRAW: begin
          // An empty rectangle enters DRAW with pix_valid low and leaves at once.
          if (!pix_valid) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (pix_ready) begin
            pix_count <= pix_count + c_cnt_one;
            if (w_last) begin
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_state   <= DONE;
            end else if (w_row_more) begin
              x <= w_jump ? r_xe[COORD_W-1:0] : x + c_step;
            end else begin
              x <= r_x0;
              y <= y + c_step;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
